serial_word_collector: RTL and testbench
========================================

Name: serial_word_collector

Overview:
- Downstream neighbour of the bit-serial two's-complement stage.
- Consumes that stage's LSB-first serial output and the matching word-start strobe, and reassembles each WIDTH-bit word.
- Presents each word on a parallel valid/ready interface to the next stage.
- Holds one completed word in an output register, while the next word shifts in behind it.

Parameters:
- WIDTH, 8: bits per serial word; legal range 2..32.
- CNT_W, $clog2(WIDTH): width of the bit counter; derived, not to be overridden.

Ports:
- t_clk, input, 1: system clock; all state updates on the rising edge.
- r_n, input, 1: asynchronous active-low reset.
- s_bit, input, 1: serial data bit, LSB first; sampled every rising edge.
- s_start, input, 1: high in the cycle that carries bit 0 of a word.
- out_word, output, WIDTH: assembled word; bit k = k-th serial bit received.
- out_valid, output, 1: out_word holds an unconsumed word.
- out_ready, input, 1: consumer accepts out_word on a rising edge when out_valid=1.
- ovf, output, 1: sticky; a completed word was dropped because the output register was still full.
- frame_err, output, 1: one-cycle pulse; s_start arrived before the current word completed.
- out_par, output, 1: present only with PARITY_EN; even parity of out_word.

Behaviour:
- Reset (r_n=0, asynchronous), applies immediately, mid-word included:
  - state=IDLE, shift register=0, counter=0.
  - out_word=0, out_valid=0, ovf=0, frame_err=0, out_par=0.
  - Any partial word is discarded.
- States are IDLE and SHIFT.
- IDLE:
  - s_start=0: s_bit is ignored.
  - s_start=1: shift[0]<=s_bit, count<=1, go to SHIFT.
- SHIFT, with s_start=0:
  - shift[count]<=s_bit, count<=count+1.
  - When count==WIDTH-1, the word completes this edge; go to IDLE, count<=0.
- SHIFT, with s_start=1 (short frame):
  - Partial word is discarded and frame_err=1 for the next cycle.
  - This bit becomes bit 0 of a new word: shift[0]<=s_bit, count<=1, stay in SHIFT.
- s_start=1 exactly in the cycle after completion is normal back-to-back framing. It is handled as IDLE+start with no gap and no error.
- Completion transfer:
  - Full word = {s_bit, shift[WIDTH-2:0]}.
  - It loads into out_word if out_valid=0, or if out_valid=1 and out_ready=1 on the same edge. In either case out_valid=1 next cycle.
  - Latency: word visible one cycle after its last bit is sampled.
- Output full:
  - If out_valid=1 and out_ready=0 at completion, the new word is dropped.
  - out_word keeps its old value and ovf<=1.
  - ovf clears only on reset.
- Handshake:
  - out_valid falls after the accepting edge unless a completion loads on the same edge.
  - out_word is stable while out_valid=1 and out_ready=0.
  - out_ready while out_valid=0 has no effect.
- Counter never exceeds WIDTH-1; no wrap beyond a word.

Optional Feature:
- Macro: SERIAL_COLLECTOR_PARITY_EN.
- Defined:
  - out_par port exists.
  - out_par is registered alongside out_word at each load and equals the XOR-reduction of the loaded word.
  - Reset value is 0.
- Undefined:
  - out_par port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package serial_pkg holds:
  - State encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - Default word width constant SER_WIDTH=8, shared with the upstream serial stage.
- One sub-module, serial_bit_counter:
  - Ports: clear, load-one, increment.
  - Outputs: count and last (count==WIDTH-1).
  - Same t_clk/r_n rules.
- The top holds the FSM, shift register, output register and flags.

Test Plan (WIDTH=8):
- Basic word: send 0x2C LSB-first (bits 0,0,1,1,0,1,0,0) with s_start on bit 0, out_ready=1 → out_word=0x2C, out_valid=1 exactly one cycle after bit 7, for one cycle.
- Two's-complement stream: feed the serial result of negating 0x05 (bits 1,1,0,1,1,1,1,1) → out_word=0xFB; with PARITY_EN, out_par=1.
- Back-to-back: 0xA5 then 0x3C with no idle cycle, out_ready=1 → two consecutive valid words, frame_err never asserted.
- Backpressure: out_ready=0, send 0x11 then 0x22 → out_word stays 0x11 and ovf=1 after the second word. Raising out_ready then pops 0x11, and out_valid=0.
- Short frame: s_start again after 3 bits, then a full 0x7E → frame_err pulses once, the partial word is never output, out_word=0x7E.
- Mid-word reset: pull r_n low at bit 4 → all outputs 0 immediately. The next full word 0x81 assembles correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants for the bit-serial datapath stages.
// Used by serial_word_collector (optional SERIAL_COLLECTOR_PARITY_EN).
package serial_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam int SER_WIDTH = 8;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } state_e;

endpackage

// File: rtl/serial_bit_counter.sv
// Bit position counter for one serial word.
// Saturates in range 0..WIDTH-1 via clear/load-one/increment controls.
module serial_bit_counter
    import serial_pkg::*;
#(
    parameter  int WIDTH = SER_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             t_clk,
    input  logic             r_n,
    input  logic             clr,
    input  logic             load_one,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load_one) begin
            cnt_q <= CNT_W'(1);
        end else if (inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign count = cnt_q;
    assign last  = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_word_collector.sv
// Reassembles LSB-first serial words into a one-deep valid/ready output.
// Define SERIAL_COLLECTOR_PARITY_EN to add the registered out_par output.
module serial_word_collector
    import serial_pkg::*;
#(
    parameter  int WIDTH = SER_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             t_clk,
    input  logic             r_n,
    input  logic             s_bit,
    input  logic             s_start,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic             frame_err
`ifdef SERIAL_COLLECTOR_PARITY_EN
    ,
    output logic             out_par
`endif
);

    state_e           state_q;
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [WIDTH-1:0] out_word_q;
    logic             out_valid_q;
    logic             ovf_q;
    logic             ferr_q;
    logic [CNT_W-1:0] count;
    logic             last;
    logic             in_shift;
    logic             complete;
    logic             load;
    logic [WIDTH-1:0] word_full;

    assign in_shift  = (state_q == S_SHIFT);
    assign complete  = in_shift & ~s_start & last;
    assign load      = complete & (~out_valid_q | out_ready);
    assign word_full = {s_bit, shift_q};

    serial_bit_counter #(
        .WIDTH    (WIDTH)
    ) u_cnt (
        .t_clk    (t_clk),
        .r_n      (r_n),
        .clr      (complete),
        .load_one (s_start),
        .inc      (in_shift & ~s_start & ~last),
        .count    (count),
        .last     (last)
    );

    // The top bit never lands in shift_q; it is taken straight from s_bit.
    always_comb begin
        shift_d = shift_q;
        if (s_start) begin
            shift_d    = '0;
            shift_d[0] = s_bit;
        end else if (in_shift && !last) begin
            for (int i = 0; i < WIDTH - 1; i++) begin
                if (CNT_W'(i) == count) begin
                    shift_d[i] = s_bit;
                end
            end
        end
    end

`ifdef SERIAL_COLLECTOR_PARITY_EN
    logic par_q;
`endif

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            ferr_q      <= 1'b0;
`ifdef SERIAL_COLLECTOR_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            shift_q <= shift_d;
            ferr_q  <= in_shift & s_start;

            case (state_q)
                S_IDLE: begin
                    if (s_start) begin
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (complete) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (load) begin
                out_word_q  <= word_full;
                out_valid_q <= 1'b1;
`ifdef SERIAL_COLLECTOR_PARITY_EN
                par_q       <= ^word_full;
`endif
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (complete && out_valid_q && !out_ready) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign out_word  = out_word_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign frame_err = ferr_q;
`ifdef SERIAL_COLLECTOR_PARITY_EN
    assign out_par   = par_q;
`endif

endmodule

// File: tb/tb_serial_word_collector.sv
// Randomized and directed bench for serial_word_collector against a queue model.
module tb_serial_word_collector;

    localparam int W = 8;

    logic         t_clk = 1'b0;
    logic         r_n;
    logic         s_bit;
    logic         s_start;
    logic [W-1:0] out_word;
    logic         out_valid;
    logic         out_ready;
    logic         ovf;
    logic         frame_err;
`ifdef SERIAL_COLLECTOR_PARITY_EN
    logic         out_par;
`endif

    serial_word_collector #(.WIDTH(W)) dut (
        .t_clk     (t_clk),
        .r_n       (r_n),
        .s_bit     (s_bit),
        .s_start   (s_start),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf),
        .frame_err (frame_err)
`ifdef SERIAL_COLLECTOR_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 t_clk = ~t_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ferr_seen = 0;

    // Reference model state
    bit           q[$];
    logic [W-1:0] m_word;
    logic         m_valid;
    logic         m_ovf;
    logic         m_ferr;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_word  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_ferr  = 1'b0;
    endtask

    task automatic model_edge(input bit sb, input bit ss, input bit rdy);
        bit           done;
        logic [W-1:0] w;
        done   = 1'b0;
        w      = '0;
        m_ferr = 1'b0;
        if (ss) begin
            if (q.size() > 0) m_ferr = 1'b1;
            q.delete();
            q.push_back(sb);
        end else if (q.size() > 0) begin
            q.push_back(sb);
            if (q.size() == W) begin
                for (int i = 0; i < W; i++) w = w + (W'(q[i]) << i);
                done = 1'b1;
                q.delete();
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_word  = w;
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".word"},  32'(out_word),  32'(m_word));
        check({tag, ".ovf"},   32'(ovf),       32'(m_ovf));
        check({tag, ".ferr"},  32'(frame_err), 32'(m_ferr));
`ifdef SERIAL_COLLECTOR_PARITY_EN
        check({tag, ".par"},   32'(out_par),   32'(^m_word));
`endif
    endtask

    task automatic step(input bit sb, input bit ss, input bit rdy,
                        input string tag);
        s_bit     = sb;
        s_start   = ss;
        out_ready = rdy;
        @(posedge t_clk);
        model_edge(sb, ss, rdy);
        #1;
        if (frame_err) ferr_seen++;
        check_all(tag);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit rdy,
                             input string tag);
        for (int i = 0; i < W; i++) step(w[i], i == 0, rdy, tag);
    endtask

    initial begin
        int f0;
        r_n       = 1'b0;
        s_bit     = 1'b0;
        s_start   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        r_n = 1'b1;
        step(1'b1, 1'b0, 1'b1, "idle_ignore");

        send_word(8'h2C, 1'b1, "basic");
        check("basic_word", 32'(out_word), 32'h2C);
        check("basic_valid", 32'(out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b1, "basic_pop");
        check("basic_one_cycle", 32'(out_valid), 32'd0);

        send_word(8'hFB, 1'b1, "neg5");
        check("neg5_word", 32'(out_word), 32'hFB);
`ifdef SERIAL_COLLECTOR_PARITY_EN
        check("neg5_par", 32'(out_par), 32'd1);
`endif
        step(1'b0, 1'b0, 1'b1, "neg5_pop");

        f0 = ferr_seen;
        send_word(8'hA5, 1'b1, "b2b_a");
        check("b2b_a_word", 32'(out_word), 32'hA5);
        send_word(8'h3C, 1'b1, "b2b_b");
        check("b2b_b_word", 32'(out_word), 32'h3C);
        check("b2b_no_ferr", 32'(ferr_seen - f0), 32'd0);
        step(1'b0, 1'b0, 1'b1, "b2b_pop");

        send_word(8'h11, 1'b0, "bp_a");
        send_word(8'h22, 1'b0, "bp_b");
        check("bp_hold", 32'(out_word), 32'h11);
        check("bp_ovf", 32'(ovf), 32'd1);
        step(1'b0, 1'b0, 1'b1, "bp_pop");
        check("bp_empty", 32'(out_valid), 32'd0);

        f0 = ferr_seen;
        step(1'b1, 1'b1, 1'b1, "short");
        step(1'b1, 1'b0, 1'b1, "short");
        step(1'b1, 1'b0, 1'b1, "short");
        send_word(8'h7E, 1'b1, "short_full");
        check("short_word", 32'(out_word), 32'h7E);
        check("short_ferr_once", 32'(ferr_seen - f0), 32'd1);
        step(1'b0, 1'b0, 1'b1, "short_pop");

        for (int i = 0; i < 4; i++) step(i == 1, i == 0, 1'b1, "mid");
        #2 r_n = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        check("mid_ovf_clr", 32'(ovf), 32'd0);
        @(posedge t_clk);
        #3 r_n = 1'b1;
        send_word(8'h81, 1'b1, "after_rst");
        check("after_rst_word", 32'(out_word), 32'h81);

        for (int c = 0; c < 3000; c++) begin
            step(1'($urandom), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) != 0), "rand");
        end
        for (int c = 0; c < 60; c++) begin
            send_word(W'($urandom), 1'($urandom), "rand_word");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
